// File: rtl/audio_mix_dcblock_pkg.sv
// Shared audio definitions: stereo mode codes, mixer FSM states and a
// saturation helper reused by the audio datapath blocks.
package audio_mix_dcblock_pkg;

    localparam logic [1:0] STEREO_ABC  = 2'd0;
    localparam logic [1:0] STEREO_ACB  = 2'd1;
    localparam logic [1:0] STEREO_MONO = 2'd2;  // code 3 is also treated as mono

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_MIX   = 3'd2,
        ST_HPF   = 3'd3,
        ST_SAT   = 3'd4
    } mix_state_t;

    // Clamp a sign-extended value to the range of a dw-bit two's complement word.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/audio_mix_dcblock_dc_blocker.sv
// Single-channel first-order DC blocker with bypass. The saturated output
// register doubles as the y_prev feedback state.
module audio_mix_dcblock_dc_blocker
    import audio_mix_dcblock_pkg::*;
#(
    parameter int AUDIO_DW  = 16,
    parameter int DCB_SHIFT = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       bypass,
    input  logic signed [AUDIO_DW+1:0] x_in,
    output logic signed [AUDIO_DW-1:0] y_out
);

    localparam int XW = AUDIO_DW + 2;
    localparam logic signed [XW-1:0] X_RESET = -$signed(XW'(1) << (AUDIO_DW - 1));

    logic signed [XW-1:0]       x_prev_q, x_prev_d;
    logic signed [AUDIO_DW-1:0] y_prev_q, y_prev_d;
    logic signed [XW-1:0]       y_prev_ext;
    logic signed [XW-1:0]       y_full;
    logic signed [XW-1:0]       y_sel;
    logic signed [31:0]         y_sat_w;

    always_comb begin
        y_prev_ext = XW'(y_prev_q);
        // Range analysis: |x - x_prev| + |y_prev| stays inside AUDIO_DW+2 bits.
        y_full     = x_in - x_prev_q + y_prev_ext - (y_prev_ext >>> DCB_SHIFT);
        y_sel      = bypass ? x_in : y_full;
        y_sat_w    = saturate({{(32 - XW){y_sel[XW-1]}}, y_sel}, AUDIO_DW);
        x_prev_d   = x_prev_q;
        y_prev_d   = y_prev_q;
        if (en) begin
            x_prev_d = x_in;
            y_prev_d = y_sat_w[AUDIO_DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_prev_q <= X_RESET;
            y_prev_q <= '0;
        end else begin
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
        end
    end

    assign y_out = y_prev_q;

endmodule

// File: rtl/audio_mix_dcblock.sv
// PSG + tape stereo mixer with per-channel DC blocking, producing signed
// samples at SAMPLE_RATE from a fractional tick generator.
module audio_mix_dcblock
    import audio_mix_dcblock_pkg::*;
#(
    parameter int SAMPLE_RATE = 48_000,
    parameter int AUDIO_DW    = 16,
    parameter int TAPE_LEVEL  = 64,
    parameter int DCB_SHIFT   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         clk_rate,
    input  logic [7:0]          ch_a,
    input  logic [7:0]          ch_b,
    input  logic [7:0]          ch_c,
    input  logic                tape_in,
    input  logic [1:0]          stereo_mode,
    input  logic                dc_bypass,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                out_valid,
    output logic                overrun
);

    localparam int XW       = AUDIO_DW + 2;
    localparam int SCALE_SH = AUDIO_DW - 10;
    localparam logic signed [XW-1:0] X_OFFSET = $signed(XW'(1) << (AUDIO_DW - 1));

    mix_state_t state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [32:0] acc_sum;
    logic        tick;
    logic        overrun_q, overrun_d;

    logic [7:0]  ch_a_q, ch_a_d, ch_b_q, ch_b_d, ch_c_q, ch_c_d;
    logic        tape_q, tape_d, bypass_q, bypass_d;
    logic [1:0]  mode_q, mode_d;

    logic [9:0]  a1, b1, c1, a2, b2, c2, tape_lvl;
    logic [9:0]  sum_l, sum_r;
    logic signed [XW-1:0] x_l_q, x_l_d, x_r_q, x_r_d;
    logic signed [AUDIO_DW-1:0] y_l, y_r;

    // Fractional rate divider: one tick per clk_rate/SAMPLE_RATE clocks on average.
    always_comb begin
        acc_sum = {1'b0, acc_q} + 33'(SAMPLE_RATE);
        tick    = (acc_sum >= {1'b0, clk_rate});
        acc_d   = tick ? 32'(acc_sum - {1'b0, clk_rate}) : acc_sum[31:0];
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE:  if (tick) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_MIX;
            ST_MIX:   state_d = ST_HPF;
            ST_HPF:   state_d = ST_SAT;
            ST_SAT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        ch_a_d   = ch_a_q;
        ch_b_d   = ch_b_q;
        ch_c_d   = ch_c_q;
        tape_d   = tape_q;
        mode_d   = mode_q;
        bypass_d = bypass_q;
        if (state_q == ST_LATCH) begin
            ch_a_d   = ch_a;
            ch_b_d   = ch_b;
            ch_c_d   = ch_c;
            tape_d   = tape_in;
            mode_d   = stereo_mode;
            bypass_d = dc_bypass;
        end
    end

    // Worst case 2*255 + 255 + TAPE_LEVEL fits the 10-bit sums.
    always_comb begin
        a1       = {2'b00, ch_a_q};
        b1       = {2'b00, ch_b_q};
        c1       = {2'b00, ch_c_q};
        a2       = {1'b0, ch_a_q, 1'b0};
        b2       = {1'b0, ch_b_q, 1'b0};
        c2       = {1'b0, ch_c_q, 1'b0};
        tape_lvl = tape_q ? 10'(TAPE_LEVEL) : 10'd0;
        case (mode_q)
            STEREO_ABC: begin
                sum_l = a2 + b1 + tape_lvl;
                sum_r = c2 + b1 + tape_lvl;
            end
            STEREO_ACB: begin
                sum_l = a2 + c1 + tape_lvl;
                sum_r = b2 + c1 + tape_lvl;
            end
            default: begin
                sum_l = a1 + b1 + c1 + tape_lvl;
                sum_r = sum_l;
            end
        endcase
        x_l_d = x_l_q;
        x_r_d = x_r_q;
        if (state_q == ST_MIX) begin
            x_l_d = $signed(XW'(sum_l) << SCALE_SH) - X_OFFSET;
            x_r_d = $signed(XW'(sum_r) << SCALE_SH) - X_OFFSET;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            overrun_q <= 1'b0;
            ch_a_q    <= '0;
            ch_b_q    <= '0;
            ch_c_q    <= '0;
            tape_q    <= 1'b0;
            mode_q    <= STEREO_ABC;
            bypass_q  <= 1'b0;
            x_l_q     <= '0;
            x_r_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            overrun_q <= overrun_d;
            ch_a_q    <= ch_a_d;
            ch_b_q    <= ch_b_d;
            ch_c_q    <= ch_c_d;
            tape_q    <= tape_d;
            mode_q    <= mode_d;
            bypass_q  <= bypass_d;
            x_l_q     <= x_l_d;
            x_r_q     <= x_r_d;
        end
    end

    // Filter registers load at the end of HPF, so the new sample is visible in SAT.
    audio_mix_dcblock_dc_blocker #(
        .AUDIO_DW  (AUDIO_DW),
        .DCB_SHIFT (DCB_SHIFT)
    ) u_dcb_l (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q == ST_HPF),
        .bypass (bypass_q),
        .x_in   (x_l_q),
        .y_out  (y_l)
    );

    audio_mix_dcblock_dc_blocker #(
        .AUDIO_DW  (AUDIO_DW),
        .DCB_SHIFT (DCB_SHIFT)
    ) u_dcb_r (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q == ST_HPF),
        .bypass (bypass_q),
        .x_in   (x_r_q),
        .y_out  (y_r)
    );

    assign left_chan  = y_l;
    assign right_chan = y_r;
    assign out_valid  = (state_q == ST_SAT);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_mix_dcblock.sv
// Bench for audio_mix_dcblock: directed steps plus randomized stimulus,
// compared every clock against a sample-level reference model.
module tb_audio_mix_dcblock;

    localparam int SR = 48_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] clk_rate = 32'd480_000;
    logic [7:0]  ch_a = '0, ch_b = '0, ch_c = '0;
    logic        tape_in = 1'b0;
    logic [1:0]  stereo_mode = 2'd0;
    logic        dc_bypass = 1'b0;
    logic [15:0] left_chan, right_chan;
    logic        out_valid, overrun;

    always #5 clk = ~clk;

    audio_mix_dcblock dut (
        .clk         (clk),
        .reset       (reset),
        .clk_rate    (clk_rate),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .tape_in     (tape_in),
        .stereo_mode (stereo_mode),
        .dc_bypass   (dc_bypass),
        .left_chan   (left_chan),
        .right_chan  (right_chan),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accumulator, cycles since the accepted tick, filter memories.
    longint m_acc;
    int     m_phase;
    int     xp_l, yp_l, xp_r, yp_r;
    int     pend_l, pend_r, exp_l, exp_r;
    bit     exp_valid, exp_ovr;
    int     cyc, last_valid_cyc, spacing_period;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit model_tick_now();
        return !reset && (m_acc + SR >= longint'(clk_rate));
    endfunction

    task automatic model_latch();
        int a, b, c, l, r, xl, xr;
        a = int'(ch_a);
        b = int'(ch_b);
        c = int'(ch_c);
        case (stereo_mode)
            2'd0:    begin l = 2 * a + b; r = 2 * c + b; end
            2'd1:    begin l = 2 * a + c; r = 2 * b + c; end
            default: begin l = a + b + c; r = l; end
        endcase
        if (tape_in) begin
            l += 64;
            r += 64;
        end
        xl = l * 64 - 32768;
        xr = r * 64 - 32768;
        if (dc_bypass) begin
            pend_l = sat16(xl);
            pend_r = sat16(xr);
        end else begin
            pend_l = sat16(xl - xp_l + yp_l - (yp_l >>> 10));
            pend_r = sat16(xr - xp_r + yp_r - (yp_r >>> 10));
        end
        xp_l = xl; yp_l = pend_l;
        xp_r = xr; yp_r = pend_r;
    endtask

    task automatic step();
        bit tk;
        @(posedge clk);
        if (reset) begin
            m_acc = 0; m_phase = 0; exp_l = 0; exp_r = 0; exp_ovr = 0;
            xp_l = -32768; xp_r = -32768; yp_l = 0; yp_r = 0;
        end else begin
            tk = (m_acc + SR >= longint'(clk_rate));
            if (m_phase == 1) model_latch();
            if (m_phase == 3) begin
                exp_l = pend_l;
                exp_r = pend_r;
            end
            if (tk && m_phase != 0) exp_ovr = 1;
            if (m_phase == 0) m_phase = tk ? 1 : 0;
            else m_phase = (m_phase == 4) ? 0 : m_phase + 1;
            m_acc = tk ? m_acc + SR - longint'(clk_rate) : m_acc + SR;
        end
        exp_valid = (m_phase == 4);
        cyc++;
        #1;
        chk("out_valid", out_valid, exp_valid);
        chk("overrun", overrun, exp_ovr);
        chk("left_chan", $signed(left_chan), exp_l);
        chk("right_chan", $signed(right_chan), exp_r);
        if (out_valid) begin
            if (spacing_period > 0 && last_valid_cyc >= 0)
                chk("valid_spacing_ok",
                    ((cyc - last_valid_cyc) >= spacing_period - 1) &&
                    ((cyc - last_valid_cyc) <= spacing_period + 1), 1);
            last_valid_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        last_valid_cyc = -1;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 60);
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!model_tick_now() && n < 60) begin
            step();
            n++;
        end
        if (!model_tick_now()) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        int prev_l, cur_l, n, nvalid;
        cyc = 0;
        last_valid_cyc = -1;
        spacing_period = 0;
        m_acc = 0; m_phase = 0; exp_ovr = 0; exp_l = 0; exp_r = 0;
        xp_l = -32768; xp_r = -32768; yp_l = 0; yp_r = 0;

        // Reset state and idle with zero inputs
        do_reset();
        chk("reset_left", $signed(left_chan), 0);
        chk("reset_right", $signed(right_chan), 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_overrun", overrun, 0);
        spacing_period = 10;
        repeat (60) step();
        spacing_period = 0;

        // Bypass, ABC then ACB
        dc_bypass = 1'b1; stereo_mode = 2'd0; ch_a = 8'd255;
        wait_valid(); wait_valid();
        chk("abc_left", $signed(left_chan), -128);
        chk("abc_right", $signed(right_chan), -32768);
        stereo_mode = 2'd1; ch_a = 8'd0; ch_b = 8'd255;
        wait_valid(); wait_valid();
        chk("acb_left", $signed(left_chan), -32768);
        chk("acb_right", $signed(right_chan), -128);

        // High-pass step response in mono
        ch_b = 8'd0; dc_bypass = 1'b0; stereo_mode = 2'd2;
        do_reset();
        wait_valid(); wait_valid();
        ch_a = 8'd255; ch_b = 8'd255; ch_c = 8'd255;
        wait_valid();
        if (left_chan != 16'h7fff) wait_valid();
        prev_l = $signed(left_chan);
        chk("step_first_sat", prev_l, 32767);
        chk("mono_identical", $signed(right_chan), prev_l);
        repeat (6) begin
            wait_valid();
            cur_l = $signed(left_chan);
            chk("hpf_decreasing", (cur_l < prev_l) && (cur_l >= 0), 1);
            prev_l = cur_l;
        end

        // Tape level with silent channels
        ch_a = 8'd0; ch_b = 8'd0; ch_c = 8'd0; dc_bypass = 1'b1; stereo_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tape_in = i[0];
            wait_valid(); wait_valid();
            chk("tape_left", $signed(left_chan), i[0] ? -28672 : -32768);
            chk("tape_right", $signed(right_chan), i[0] ? -28672 : -32768);
        end
        tape_in = 1'b0;

        // Unsupported clock ratio flags overrun
        clk_rate = 32'd192_000;
        do_reset();
        repeat (30) step();
        chk("overrun_sticky", overrun, 1);

        // Reset two clocks after a tick aborts the sample
        clk_rate = 32'd480_000;
        do_reset();
        ch_a = 8'd200;
        wait_tick();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvalid = 0;
        repeat (6) begin
            step();
            if (out_valid) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        chk("abort_left", $signed(left_chan), 0);
        chk("abort_right", $signed(right_chan), 0);

        // Latency and input capture in LATCH
        wait_tick();
        ch_a = 8'd100; ch_b = 8'd20; ch_c = 8'd0; stereo_mode = 2'd0; dc_bypass = 1'b1;
        n = 0;
        step(); n++;
        step(); n++;
        ch_a = 8'($urandom_range(0, 255)); ch_b = 8'($urandom_range(0, 255));
        ch_c = 8'($urandom_range(0, 255)); stereo_mode = 2'd2; dc_bypass = 1'b0;
        while (!out_valid && n < 20) begin
            step(); n++;
        end
        chk("latency", n, 4);
        chk("latched_left", $signed(left_chan), -18688);
        chk("latched_right", $signed(right_chan), -31488);

        // Randomized inputs and clock ratios
        for (int k = 0; k < 4; k++) begin
            clk_rate = (k == 0) ? 32'd240_000 : 32'($urandom_range(240_000, 1_000_000));
            do_reset();
            repeat (300) begin
                if ($urandom_range(0, 3) == 0) begin
                    ch_a = 8'($urandom_range(0, 255));
                    ch_b = 8'($urandom_range(0, 255));
                    ch_c = 8'($urandom_range(0, 255));
                    tape_in = 1'($urandom_range(0, 1));
                    stereo_mode = 2'($urandom_range(0, 3));
                    dc_bypass = ($urandom_range(0, 3) == 0);
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
